// File: rtl/act_pwl_if.sv
// Streaming beat interface for act_pwl_unit: input beat handshake and output beat handshake.
interface act_pwl_if #(
    parameter int unsigned LANES      = 32,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OUT_WIDTH  = 16
);
    logic                          i_valid;
    logic                          o_ready;
    logic [LANES*DATA_WIDTH-1:0]   i_dat;
    logic [3:0]                    i_shift;
    logic                          o_valid;
    logic                          i_ready;
    logic [LANES*OUT_WIDTH-1:0]    o_dat;
    logic [LANES-1:0]              o_sat;

    modport master (
        output i_valid, i_dat, i_shift, i_ready,
        input  o_ready, o_valid, o_dat, o_sat
    );

    modport slave (
        input  i_valid, i_dat, i_shift, i_ready,
        output o_ready, o_valid, o_dat, o_sat
    );
endinterface

// File: rtl/act_pwl_unit.sv
// Multi-lane piecewise-linear activation (a*x+b) with double-buffered coefficient LUT, 3-stage pipeline.
// Optional output saturation when ACT_SAT_EN is defined; otherwise results wrap to OUT_WIDTH.
module act_pwl_unit #(
    parameter int unsigned LANES       = 32,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COE_A_WIDTH = 8,
    parameter int unsigned COE_B_WIDTH = 16,
    parameter int unsigned LUT_DEPTH   = 16,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned OUT_WIDTH   = 16
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    act_pwl_if.slave                           pipe,
    input  logic                               i_lut_we,
    input  logic [ADDR_WIDTH-1:0]              i_lut_addr,
    input  logic [COE_A_WIDTH+COE_B_WIDTH-1:0] i_lut_wdata,
    input  logic                               i_lut_swap,
    output logic                               o_active_bank
);
    localparam int unsigned COE_WIDTH  = COE_A_WIDTH + COE_B_WIDTH;
    localparam int unsigned PROD_WIDTH = COE_A_WIDTH + DATA_WIDTH;
    localparam int unsigned RES_WIDTH  = ((PROD_WIDTH > COE_B_WIDTH) ? PROD_WIDTH : COE_B_WIDTH) + 1;
    localparam int unsigned IDX_WIDTH  = DATA_WIDTH + ADDR_WIDTH + 1;

    localparam logic signed [IDX_WIDTH-1:0]  IDX_BIAS = IDX_WIDTH'(LUT_DEPTH / 2);
    localparam logic signed [IDX_WIDTH-1:0]  IDX_MAX  = IDX_WIDTH'(LUT_DEPTH - 1);
    localparam logic signed [RES_WIDTH-1:0]  OUT_MAX  = RES_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [RES_WIDTH-1:0]  OUT_MIN  = ~OUT_MAX;

    logic en;

    // Coefficient storage: [bank][segment] = {a, b}
    logic [COE_WIDTH-1:0] lut [2][LUT_DEPTH];

    // Stage 1 registers
    logic                          v1;
    logic                          tag1;
    logic signed [DATA_WIDTH-1:0]  x1   [LANES];
    logic [ADDR_WIDTH-1:0]         idx1 [LANES];

    // Stage 2 registers
    logic                          v2;
    logic signed [DATA_WIDTH-1:0]  x2   [LANES];
    logic signed [COE_A_WIDTH-1:0] a2   [LANES];
    logic signed [COE_B_WIDTH-1:0] b2   [LANES];

    // Combinational per-lane signals
    logic signed [DATA_WIDTH-1:0]  lane_x_c [LANES];
    logic signed [IDX_WIDTH-1:0]   seg_c    [LANES];
    logic [ADDR_WIDTH-1:0]         idx_c    [LANES];
    logic signed [RES_WIDTH-1:0]   r_c      [LANES];
    logic [OUT_WIDTH-1:0]          res_c    [LANES];
    logic                          sat_c    [LANES];

    // Whole pipeline moves together; a full output register blocks everything behind it
    assign en           = !pipe.o_valid | pipe.i_ready;
    assign pipe.o_ready = en;

    // Segment index: arithmetic shift, recentre, clamp into the table
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_x_c[k] = signed'(pipe.i_dat[k*DATA_WIDTH +: DATA_WIDTH]);
            seg_c[k]    = IDX_WIDTH'(lane_x_c[k] >>> pipe.i_shift) + IDX_BIAS;
            idx_c[k]    = '0;
            if (seg_c[k][IDX_WIDTH-1]) begin
                idx_c[k] = '0;
            end else if (seg_c[k] > IDX_MAX) begin
                idx_c[k] = ADDR_WIDTH'(LUT_DEPTH - 1);
            end else begin
                idx_c[k] = seg_c[k][ADDR_WIDTH-1:0];
            end
        end
    end

    // Full-width multiply-add, then reduce to the output width
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            r_c[k]   = RES_WIDTH'(a2[k]) * RES_WIDTH'(x2[k]) + RES_WIDTH'(b2[k]);
            res_c[k] = OUT_WIDTH'(r_c[k]);
            sat_c[k] = 1'b0;
`ifdef ACT_SAT_EN
            if (r_c[k] > OUT_MAX) begin
                res_c[k] = OUT_WIDTH'(OUT_MAX);
                sat_c[k] = 1'b1;
            end else if (r_c[k] < OUT_MIN) begin
                res_c[k] = OUT_WIDTH'(OUT_MIN);
                sat_c[k] = 1'b1;
            end
`endif
        end
    end

    // Host side: writes always target the inactive bank and are never stalled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_active_bank <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < LUT_DEPTH; e++) begin
                    lut[b][e] <= '0;
                end
            end
        end else begin
            if (i_lut_we) begin
                lut[~o_active_bank][i_lut_addr] <= i_lut_wdata;
            end
            if (i_lut_swap) begin
                o_active_bank <= ~o_active_bank;
            end
        end
    end

    // Datapath pipeline; the bank tag rides with the beat so later swaps cannot touch it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            tag1         <= 1'b0;
            pipe.o_valid <= 1'b0;
            pipe.o_dat   <= '0;
            pipe.o_sat   <= '0;
            for (int k = 0; k < LANES; k++) begin
                x1[k]   <= '0;
                idx1[k] <= '0;
                x2[k]   <= '0;
                a2[k]   <= '0;
                b2[k]   <= '0;
            end
        end else if (en) begin
            v1           <= pipe.i_valid;
            tag1         <= o_active_bank;
            v2           <= v1;
            pipe.o_valid <= v2;
            for (int k = 0; k < LANES; k++) begin
                x1[k]   <= lane_x_c[k];
                idx1[k] <= idx_c[k];
                x2[k]   <= x1[k];
                a2[k]   <= signed'(lut[tag1][idx1[k]][COE_WIDTH-1 -: COE_A_WIDTH]);
                b2[k]   <= signed'(lut[tag1][idx1[k]][COE_B_WIDTH-1:0]);
                pipe.o_dat[k*OUT_WIDTH +: OUT_WIDTH] <= res_c[k];
                pipe.o_sat[k]                        <= sat_c[k];
            end
        end
    end
endmodule

// File: doc/act_pwl_unit.md
# act_pwl_unit

Multi-lane piecewise-linear activation unit for the NPU core datapath. It sits after the requantisation/rounding stage and before the output writeback. Each lane selects a segment from a shared, double-buffered coefficient LUT and computes `a*x + b` through a 3-stage valid/ready pipeline. The LUT has an active bank and a shadow bank, so coefficients can be reloaded by the host while traffic flows and swapped atomically between beats.

## Interface
- LANES, 32, parallel lanes per beat
- DATA_WIDTH, 8, signed input element width
- COE_A_WIDTH, 8, signed slope width
- COE_B_WIDTH, 16, signed offset width
- LUT_DEPTH, 16, segments per bank (power of two)
- ADDR_WIDTH, 4, log2(LUT_DEPTH)
- OUT_WIDTH, 16, signed output element width
- i_clk  in  1  clock
- i_rst_n  in  1  reset (see Operation)
- i_valid  in  1  input beat valid
- o_ready  out  1  input beat accepted when i_valid & o_ready
- i_dat  in  LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_shift  in  4  segment shift, sampled with the beat
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream ready
- o_dat  out  LANES*OUT_WIDTH  lane k at bits [k*OUT_WIDTH +: OUT_WIDTH]
- o_sat  out  LANES  per-lane saturation flag, aligned with o_dat
- i_lut_we  in  1  write the shadow bank
- i_lut_addr  in  ADDR_WIDTH  write address
- i_lut_wdata  in  COE_A_WIDTH+COE_B_WIDTH  {a, b}; a in the MSBs
- i_lut_swap  in  1  single-cycle pulse; toggles the active bank
- o_active_bank  out  1  current active bank

## Operation
- Reset: the block uses i_rst_n, asynchronous, active-low, with clock i_clk.
  - On reset, all pipeline valids are cleared, both banks are zeroed, and o_active_bank is 0.
  - o_dat, o_sat and o_valid reset to 0.
  - Reset mid-stream drops all in-flight beats.
- Stall rule: global enable `en = !o_valid | i_ready`, and `o_ready = en`.
  - All stages advance only when en is high.
  - Bubbles are not collapsed.
  - Order is preserved.
- Segment index per lane:
  - `s = x >>> i_shift` (arithmetic shift).
  - `idx = s + LUT_DEPTH/2`, clamped to the range [0, LUT_DEPTH-1].
- Bank tag: each accepted beat latches o_active_bank at S1 and carries it down the pipeline. A swap never affects a beat that is already in flight.
- Result per lane:
  - `r = a*x + sign_ext(b)`, computed at full width, i.e. max(COE_A_WIDTH+DATA_WIDTH, COE_B_WIDTH)+1 bits.
  - r is then reduced to OUT_WIDTH (see Configuration).
- Writes:
  - i_lut_we writes i_lut_wdata to the inactive bank at i_lut_addr.
  - Writes are never stalled by en.
  - The active bank is read-only to the host.
- Swap:
  - i_lut_swap toggles o_active_bank on the next clock edge.
  - A beat accepted in the swap cycle uses the old bank.
- Write and swap in the same cycle: the write lands in the pre-swap inactive bank, i.e. the bank that becomes active.

## Timing
- S1: register x, idx, shift and bank tag.
- S2: registered LUT read of {a, b} per lane; x is delayed one stage.
- S3: multiply-add and reduction, registered into o_dat/o_sat.
- With i_ready held high, latency from acceptance to o_valid is 3 cycles, at a throughput of 1 beat/cycle.
- When o_valid & !i_ready:
  - o_dat, o_sat and o_valid hold stable.
  - o_ready is 0 in the same cycle.
  - Up to 3 beats are held in the pipeline.
- A LUT write takes effect on the next edge. It becomes visible to beats only after a subsequent swap.

## Configuration
- ACT_SAT_EN defined:
  - r is saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - o_sat[k] = 1 when lane k was clipped.
- ACT_SAT_EN undefined:
  - r is truncated to its low OUT_WIDTH bits (two's-complement wrap).
  - o_sat is tied to 0.

## Test plan
- Reset: assert i_rst_n=0 mid-stream. Required: o_valid=0, o_dat=0, o_active_bank=0, and no stale beat appears after release.
- Identity with latency:
  - Setup: write all 16 entries with a=1, b=0, then pulse swap.
  - Stimulus: i_dat all lanes -5, i_shift=0.
  - Required: exactly 3 cycles later, o_valid=1 and every lane is -5 (0xFFFB).
- Clamp:
  - Setup: entries written with a=0, b=addr, then swap.
  - Stimulus and required response: x=127, shift 0 gives 15; x=-128, shift 4 gives 0; x=-20, shift 2 gives 3.
- Saturation:
  - Setup: a=127, b=32767.
  - Stimulus: x=127.
  - Required with ACT_SAT_EN: output 32767, o_sat=1.
  - Required without ACT_SAT_EN: output -16640, o_sat=0.
- Backpressure:
  - Stimulus: send beats 1..6 (value n on all lanes) while holding i_ready=0 for 5 cycles after the first output appears.
  - Required: o_ready deasserts, o_dat holds, and all 6 beats arrive in order exactly once.
- Swap mid-stream:
  - Setup: bank0 b=100, bank1 b=200, a=0.
  - Stimulus: stream continuously and pulse swap on beat 3's accept cycle, together with a write.
  - Required: beats 1-3 output 100, beats 4+ output 200, and the write is visible in the new active bank.
